// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - EX-stage MDU request/HI-LO result bundle
interface mdu_hilo_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (
        output start, md_op, rs_data, rt_data, req,
        input  hi, lo, busy
    );

    modport slave (
        input  start, md_op, rs_data, rt_data, req,
        output hi, lo, busy
    );
endinterface

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - multi-cycle multiply/divide unit holding architectural HI/LO
// Optional madd/maddu/msub/msubu (ops 7-10) enabled by defining MDU_MADD_EN.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_hilo_if.slave bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [63:0] pend, pend_n;
    logic        pend_wr, pend_wr_n;
    logic [31:0] hi_r, hi_n, lo_r, lo_n;

    logic [31:0] rs, rt;
    logic        accept;
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, sdiv_b, udiv_b, sq, sr, squot, srem;
    logic [63:0] res;
    logic        res_wr, res_multi;
    logic [4:0]  res_cnt;

    assign rs     = bus.rs_data;
    assign rt     = bus.rt_data;
    assign accept = bus.start && (state == S_IDLE) && !bus.req;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide on magnitudes avoids the INT_MIN / -1 overflow case.
    assign abs_a  = rs[31] ? -rs : rs;
    assign abs_b  = rt[31] ? -rt : rt;
    assign sdiv_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign udiv_b = (rt == 32'd0) ? 32'd1 : rt;
    assign sq     = abs_a / sdiv_b;
    assign sr     = abs_a % sdiv_b;
    assign squot  = (rs[31] ^ rt[31]) ? -sq : sq;
    assign srem   = rs[31] ? -sr : sr;

    always_comb begin
        res       = 64'd0;
        res_wr    = 1'b0;
        res_multi = 1'b0;
        res_cnt   = 5'(MULT_CYCLES - 1);
        case (bus.md_op)
            OP_MULT: begin
                res = prod_s; res_wr = 1'b1; res_multi = 1'b1;
            end
            OP_MULTU: begin
                res = prod_u; res_wr = 1'b1; res_multi = 1'b1;
            end
            OP_DIV: begin
                res = {srem, squot}; res_wr = (rt != 32'd0); res_multi = 1'b1;
                res_cnt = 5'(DIV_CYCLES - 1);
            end
            OP_DIVU: begin
                res = {rs % udiv_b, rs / udiv_b}; res_wr = (rt != 32'd0); res_multi = 1'b1;
                res_cnt = 5'(DIV_CYCLES - 1);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                res = {hi_r, lo_r} + prod_s; res_wr = 1'b1; res_multi = 1'b1;
            end
            OP_MADDU: begin
                res = {hi_r, lo_r} + prod_u; res_wr = 1'b1; res_multi = 1'b1;
            end
            OP_MSUB: begin
                res = {hi_r, lo_r} - prod_s; res_wr = 1'b1; res_multi = 1'b1;
            end
            OP_MSUBU: begin
                res = {hi_r, lo_r} - prod_u; res_wr = 1'b1; res_multi = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pend_n    = pend;
        pend_wr_n = pend_wr;
        hi_n      = hi_r;
        lo_n      = lo_r;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bus.md_op == OP_MTHI) hi_n = rs;
                    if (bus.md_op == OP_MTLO) lo_n = rs;
                    if (res_multi) begin
                        state_n   = S_BUSY;
                        cnt_n     = res_cnt;
                        pend_n    = res;
                        pend_wr_n = res_wr;
                    end
                end
            end
            S_BUSY: begin
                if (cnt != 5'd0) begin
                    cnt_n = cnt - 5'd1;
                end else begin
                    state_n = S_IDLE;
                    if (pend_wr) {hi_n, lo_n} = pend;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            pend    <= 64'd0;
            pend_wr <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pend    <= pend_n;
            pend_wr <= pend_wr_n;
            hi_r    <= hi_n;
            lo_r    <= lo_n;
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = (state == S_BUSY);
endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - scoreboard bench for mdu_hilo with directed vectors
module tb_mdu_hilo;
    logic clk = 1'b0;
    logic reset;
    logic chk;

    mdu_hilo_if bus ();

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    int   busy_cnt = 0;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act === req_v) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req_v);
    endtask

    // Monitor: an output event is busy falling, or an explicit strobe for zero-latency ops.
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy === 1'b1) begin
            busy_cnt++;
        end else if (prev_busy || chk) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_event: got output event expected none (hi=0x%08h lo=0x%08h)",
                         bus.hi, bus.lo);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_hi"}, bus.hi, e.hi);
                check({e.name, "_lo"}, bus.lo, e.lo);
                check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.cyc));
            end
            busy_cnt = 0;
        end
        prev_busy = bus.busy;
    end

    task automatic expect_ev(input string name, input logic [31:0] h, input logic [31:0] l, input int c);
        exp_t e;
        e.name = name; e.hi = h; e.lo = l; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
        bus.start = 1'b1; bus.md_op = op; bus.rs_data = a; bus.rt_data = b; bus.req = rq;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.md_op = 4'd0; bus.req = 1'b0;
    endtask

    task automatic strobe();
        chk = 1'b1;
        @(posedge clk); #1;
        chk = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            $display("FAIL wait_idle_timeout: got busy after 50 cycles expected idle");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; chk = 1'b0;
        bus.start = 1'b0; bus.md_op = 4'd0; bus.rs_data = '0; bus.rt_data = '0; bus.req = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        expect_ev("reset", 32'h0, 32'h0, 0);
        strobe();

        issue(4'd5, 32'h12345678, 32'h0, 1'b0);
        issue(4'd6, 32'h9ABCDEF0, 32'h0, 1'b0);
        expect_ev("mthi_mtlo", 32'h12345678, 32'h9ABCDEF0, 0);
        strobe();

        expect_ev("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0); wait_idle();
        expect_ev("multu", 32'h00000002, 32'hFFFFFFFA, 5);
        issue(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0); wait_idle();

        expect_ev("div_neg7_2", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0); wait_idle();
        expect_ev("div_intmin", 32'h0, 32'h80000000, 10);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0); wait_idle();

        issue(4'd5, 32'hAA, 32'h0, 1'b0);
        issue(4'd6, 32'hBB, 32'h0, 1'b0);
        expect_ev("mt_aa_bb", 32'hAA, 32'hBB, 0);
        strobe();
        expect_ev("divu_by_zero", 32'hAA, 32'hBB, 10);
        issue(4'd4, 32'd100, 32'd0, 1'b0); wait_idle();

        expect_ev("divu_100_7", 32'd2, 32'd14, 10);
        issue(4'd4, 32'd100, 32'd7, 1'b0); wait_idle();
        expect_ev("div_7_neg2", 32'd1, 32'hFFFFFFFD, 10);
        issue(4'd3, 32'd7, 32'hFFFFFFFE, 1'b0); wait_idle();

        issue(4'd1, 32'h10000, 32'h10000, 1'b1);
        expect_ev("mult_req_blocked", 32'd1, 32'hFFFFFFFD, 0);
        strobe();

        expect_ev("mult_req_in_busy", 32'd1, 32'd0, 5);
        issue(4'd1, 32'h10000, 32'h10000, 1'b0);
        @(posedge clk); #1 bus.req = 1'b1;
        @(posedge clk); #1 bus.req = 1'b0;
        wait_idle();

        issue(4'd12, 32'h55, 32'h66, 1'b0);
        expect_ev("reserved_op", 32'd1, 32'd0, 0);
        strobe();
        issue(4'd0, 32'h55, 32'h66, 1'b0);
        expect_ev("op_none", 32'd1, 32'd0, 0);
        strobe();

        expect_ev("reset_mid_div", 32'd0, 32'd0, 3);
        issue(4'd3, 32'd100, 32'd3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        wait_idle();

`ifdef MDU_MADD_EN
        issue(4'd5, 32'h0, 32'h0, 1'b0);
        issue(4'd6, 32'hFFFFFFFF, 32'h0, 1'b0);
        expect_ev("madd_pre", 32'h0, 32'hFFFFFFFF, 0);
        strobe();
        expect_ev("madd_carry", 32'd1, 32'd0, 5);
        issue(4'd7, 32'd1, 32'd1, 1'b0); wait_idle();
        expect_ev("msub_borrow", 32'd0, 32'hFFFFFFFF, 5);
        issue(4'd9, 32'd1, 32'd1, 1'b0); wait_idle();
`else
        issue(4'd7, 32'd1, 32'd1, 1'b0);
        expect_ev("madd_disabled", 32'd0, 32'd0, 0);
        strobe();
`endif

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
